// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic-array output path.
// psum_collector and its accumulation buffer import this package.
package tpu_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} psum_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 32;

    // Sign-extend a default-width partial sum to the default accumulator width.
    function automatic logic [DEF_ACC_WIDTH-1:0] sext(input logic [DEF_DATA_WIDTH-1:0] d);
        return DEF_ACC_WIDTH'($signed(d));
    endfunction

endpackage

// File: rtl/psum_acc_buf.sv
// ROWS x ACC_WIDTH accumulation buffer: one write port that either overwrites
// or adds into an entry, plus a combinational read port.
module psum_acc_buf #(
    parameter int ROWS      = 16,
    parameter int ACC_WIDTH = 32,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_acc,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [ACC_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [ACC_WIDTH-1:0] rd_data
);

    logic [ACC_WIDTH-1:0] mem [ROWS];

    // Clearing on reset guarantees no residue from an abandoned run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_acc ? (mem[wr_addr] + wr_data) : wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_collector.sv
// Collects NUM_TILES bursts of ROWS partial sums from a deskew delay queue,
// accumulates them element-wise and drains the column over valid/ready.
module psum_collector
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int ROWS       = 16,
    parameter int NUM_TILES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    // Output handshake: a word moves when out_valid && out_ready on a rising
    // edge; out_data/out_last stay stable while out_valid is high and
    // out_ready is low. The input side has no backpressure.

    psum_state_t          state, state_nxt;
    logic [ROW_W-1:0]     row_cnt, rd_ptr;
    logic [TILE_W-1:0]    tile_cnt;
    logic                 last_row, last_tile, rd_last, xfer;
    logic                 wr_en, wr_acc;
    logic [ROW_W-1:0]     wr_addr;
    logic [ACC_WIDTH-1:0] data_ext, rd_data;

    assign data_ext  = ACC_WIDTH'($signed(data_in));
    assign last_row  = (row_cnt == ROW_W'(ROWS - 1));
    assign last_tile = (tile_cnt == TILE_W'(NUM_TILES - 1));
    assign rd_last   = (rd_ptr == ROW_W'(ROWS - 1));
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable_in) begin
                    state_nxt = (ROWS == 1 && NUM_TILES == 1) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (enable_in && last_row && last_tile) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (xfer && rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        wr_en     = 1'b0;
        wr_acc    = 1'b0;
        wr_addr   = row_cnt;
        case (state)
            IDLE: begin
                wr_en   = enable_in;
                wr_addr = '0;
            end
            ACCUM: begin
                wr_en  = enable_in;
                wr_acc = (tile_cnt != '0);
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = rd_last;
            end
            default: ;
        endcase
    end

    assign out_data = out_valid ? rd_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt  <= '0;
            tile_cnt <= '0;
            rd_ptr   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= xfer && out_last;
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        rd_ptr <= '0;
                        // A single-row burst completes its tile with the first word.
                        if (ROWS == 1) begin
                            row_cnt  <= '0;
                            tile_cnt <= (NUM_TILES == 1) ? '0 : TILE_W'(1);
                        end else begin
                            row_cnt  <= ROW_W'(1);
                            tile_cnt <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (enable_in) begin
                        if (last_row) begin
                            row_cnt  <= '0;
                            tile_cnt <= last_tile ? '0 : tile_cnt + 1'b1;
                            rd_ptr   <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (enable_in) overflow <= 1'b1;
                    if (xfer) rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    psum_acc_buf #(
        .ROWS      (ROWS),
        .ACC_WIDTH (ACC_WIDTH),
        .ADDR_W    (ROW_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_acc  (wr_acc),
        .wr_addr (wr_addr),
        .wr_data (data_ext),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector at default parameters: accumulate, gaps,
// backpressure, signed wrap, overflow flag and mid-run reset.
module tb_psum_collector;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int ROWS = 16;
    localparam int NT   = 4;

    logic          clk;
    logic          rst;
    logic          enable_in;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          busy;
    logic          overflow;

    int n_pass  = 0;
    int n_total = 0;
    logic [AW-1:0] exp_q[$];

    psum_collector #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .ROWS       (ROWS),
        .NUM_TILES  (NT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_in (enable_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // ---------------- drivers ----------------
    // mode 0: row i -> i+1; 1: tiles -5,+3,-5,+3; 2: 0x7FFFFFFF,1,0,0; 3: junk 100+i
    function automatic logic [31:0] word_val(input int mode, input int t, input int i);
        case (mode)
            0:       return 32'(i + 1);
            1:       return (t % 2 == 0) ? 32'hFFFF_FFFB : 32'd3;
            2:       return (t == 0) ? 32'h7FFF_FFFF : ((t == 1) ? 32'd1 : 32'd0);
            default: return 32'(100 + i);
        endcase
    endfunction

    task automatic send_tiles(input int mode, input bit gap, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            if (w == ROWS * NT - 1) check("valid_before_last", out_valid, 1'b0);
            enable_in = 1'b1;
            data_in   = word_val(mode, w / ROWS, w % ROWS);
            tick();
            enable_in = 1'b0;
            data_in   = '0;
            if (gap && w != nwords - 1) tick();
        end
    endtask

    task automatic push_const(input logic [31:0] v);
        for (int i = 0; i < ROWS; i++) exp_q.push_back(v);
    endtask

    task automatic push_basic();
        for (int i = 0; i < ROWS; i++) exp_q.push_back(32'(4 * (i + 1)));
    endtask

    // Scoreboard drain: pops one expected word per row; optional stall/injection.
    task automatic drain(input int stall_at, input int stall_len, input int inj_at);
        logic [31:0] exp;
        int budget;
        for (int i = 0; i < ROWS; i++) begin
            budget = 0;
            while (!out_valid && budget < 20) begin
                tick();
                budget++;
            end
            check("drain_valid", out_valid, 1'b1);
            exp = exp_q.pop_front();
            check("drain_data", out_data, exp);
            check("drain_last", out_last, (i == ROWS - 1));
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, exp);
                end
                out_ready = 1'b1;
            end
            if (i == inj_at) begin
                enable_in = 1'b1;
                data_in   = 32'h0000_DEAD;
            end
            tick();
            enable_in = 1'b0;
            data_in   = '0;
            if (i == inj_at) check("overflow_set", overflow, 1'b1);
        end
        check("done_pulse", done, 1'b1);
        check("busy_fall", busy, 1'b0);
        check("valid_fall", out_valid, 1'b0);
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        enable_in = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // Basic back-to-back accumulate: rows 4,8,...,64.
        push_basic();
        send_tiles(0, 1'b0, ROWS * NT);
        check("basic_latency", out_valid, 1'b1);
        drain(-1, 0, -1);

        // Gapped input gives identical results.
        push_basic();
        send_tiles(0, 1'b1, ROWS * NT);
        check("gap_latency", out_valid, 1'b1);
        drain(-1, 0, -1);

        // Backpressure at rd_ptr=5 for 3 cycles.
        push_basic();
        send_tiles(0, 1'b0, ROWS * NT);
        drain(5, 3, -1);

        // Dropped word during drain sets sticky overflow.
        check("overflow_clear", overflow, 1'b0);
        push_basic();
        send_tiles(0, 1'b0, ROWS * NT);
        drain(-1, 0, 3);
        check("overflow_sticky", overflow, 1'b1);
        push_basic();
        send_tiles(0, 1'b0, ROWS * NT);
        check("overflow_next_run", overflow, 1'b1);
        drain(-1, 0, -1);

        // Signed accumulation: -5+3-5+3 = -4.
        push_const(32'hFFFF_FFFC);
        send_tiles(1, 1'b0, ROWS * NT);
        drain(-1, 0, -1);

        // Modular wrap: 0x7FFFFFFF + 1 = 0x80000000.
        push_const(32'h8000_0000);
        send_tiles(2, 1'b0, ROWS * NT);
        drain(-1, 0, -1);

        // Reset after 2.5 tiles of junk, then a clean basic run.
        send_tiles(3, 1'b0, 40);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        tick();
        push_basic();
        send_tiles(0, 1'b0, ROWS * NT);
        check("post_rst_latency", out_valid, 1'b1);
        drain(-1, 0, -1);
        check("post_rst_overflow", overflow, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream consumer of one column's deskew delay queue at the systolic-array output.
- Captures enable-tagged partial-sum words and accumulates NUM_TILES bursts of ROWS words element-wise into a local buffer.
- Drains the finished result column to the result writer over a valid/ready handshake.
- The input side has no backpressure, because the delay queue cannot stall.

Parameters:
- DATA_WIDTH, 32: width of incoming partial sums (signed two's complement).
- ACC_WIDTH, 32: accumulator and output width; must be >= DATA_WIDTH.
- ROWS, 16: words per tile burst, which is also the buffer depth.
- NUM_TILES, 4: K-dimension tiles accumulated per result; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- enable_in  input  1  data_in valid this cycle.
- data_in  input  DATA_WIDTH  partial sum from the delay queue.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  ACC_WIDTH  accumulated result word.
- out_last  output  1  high with the final word (row ROWS-1).
- done  output  1  one-cycle pulse after the final drain handshake.
- busy  output  1  state is not IDLE.
- overflow  output  1  sticky flag: an input word was dropped.

Behaviour:
- Interface (already decided): one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; row_cnt, tile_cnt, rd_ptr = 0; all buffer entries = 0; out_valid=0, out_data=0, out_last=0, done=0, busy=0, overflow=0.
- Reset mid-operation: the run is abandoned with no residue in the buffer. Reset has priority over all other events.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - enable_in=1: write buf[0] = sext(data_in), row_cnt=1, tile_cnt=0, go to ACCUM.
  - Special case ROWS=1 and NUM_TILES=1: go directly to DRAIN.
- ACCUM, on each enable_in=1 cycle:
  - tile_cnt==0: buf[row_cnt] = sext(data_in) (overwrite).
  - tile_cnt>0: buf[row_cnt] = buf[row_cnt] + sext(data_in), modulo 2^ACC_WIDTH, no saturation.
  - row_cnt==ROWS-1: row_cnt wraps to 0 and tile_cnt increments.
  - Accepted word is row ROWS-1 of tile NUM_TILES-1: go to DRAIN and set rd_ptr=0.
- ACCUM gaps: cycles with enable_in=0 are ignored, so any gap length is legal.
- DRAIN outputs:
  - out_valid=1 and out_data=buf[rd_ptr].
  - out_last = (rd_ptr==ROWS-1).
- DRAIN handshake:
  - A transfer occurs when out_valid and out_ready are both high; rd_ptr increments.
  - On the transfer with out_last=1: go to IDLE and pulse done=1 for exactly one cycle.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Latency:
  - out_valid rises on the cycle after the final input word is sampled.
  - With out_ready held high, the drain takes exactly ROWS cycles.
- enable_in=1 during DRAIN: the word is dropped, the buffer and drain are unaffected, and overflow is set. overflow clears only on rst.
- enable_in=1 on the cycle the state returns to IDLE: the word starts a new run, as in IDLE.
- out_ready while not in DRAIN: ignored.
- sext: sign-extend DATA_WIDTH to ACC_WIDTH; it is the identity when the widths are equal.

Decomposition:
- Shared package tpu_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} psum_state_t;
  - default width constants (DATA_WIDTH=32, ACC_WIDTH=32);
  - a sext helper function.
- One natural sub-module, psum_acc_buf:
  - ROWS x ACC_WIDTH register array with synchronous clear;
  - write port with an overwrite/accumulate select;
  - combinational read port at rd_ptr.
- FSM and counters stay in psum_collector.

Test Plan:
- Basic accumulate: defaults; 4 back-to-back bursts, tile t row i data = i+1 -> rows out 4,8,...,64; out_last only on 64; done pulses once; busy falls with done.
- Gapped input: same data with enable_in toggling 1,0,1,0 -> identical output; out_valid rises exactly one cycle after the last enabled word.
- Backpressure: during drain, out_ready=0 for 3 cycles at rd_ptr=5 -> out_data holds 24 (4*(5+1)) with out_valid=1; all 16 words appear once, in order.
- Signed/wrap: tiles alternate -5,+3,-5,+3 -> every row 0xFFFFFFFC (-4); separate run 0x7FFFFFFF then 1,0,0 -> 0x80000000.
- Overflow: enable_in=1 with data 0xDEAD during drain -> overflow=1 and stays 1; drained values unchanged; the next run is unaffected apart from the flag.
- Reset mid-ACCUM: rst after 2.5 tiles, then run the basic accumulate -> outputs exactly 4,8,...,64; overflow=0; no residue.
